// File: rtl/rgb565_dvp_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb565_dvp_tx_if
// Brief    : RGB565 pixel stream handshake between a pixel source and the DVP transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface rgb565_dvp_tx_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, input  pix_ready);
  modport slave  (input  pix_data, input  pix_valid, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/rgb565_dvp_tx.sv
`default_nettype none
// ============================================================================
// Module   : rgb565_dvp_tx
// Brief    : RGB565 pixel stream to 8-bit DVP (vsync/href/data) frame generator.
//            Optional macro RGB565_RB_SWAP_EN swaps the R and B fields of each pixel.
// Revision : 1.0 - initial release
// ============================================================================
module rgb565_dvp_tx #(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 720,
  parameter int VS_LINES = 4,
  parameter int V_BACK   = 20,
  parameter int V_FRONT  = 5
) (
  input  wire logic           pclk,
  input  wire logic           rst_n,
  input  wire logic           enable,
  rgb565_dvp_tx_if.slave      pix,
  output logic                vs_o,
  output logic                de_o,
  output logic [7:0]          pdata_o,
  output logic                underrun_o,
  output logic                frame_done_o
);

  localparam int c_LINE_CYC = 2*H_ACTIVE + H_BLANK;
  localparam int c_BW       = $clog2(c_LINE_CYC);
  localparam int c_MAXL_A   = (VS_LINES > V_BACK)  ? VS_LINES : V_BACK;
  localparam int c_MAXL_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int c_MAXL     = (c_MAXL_A > c_MAXL_B) ? c_MAXL_A : c_MAXL_B;
  localparam int c_LW       = $clog2(c_MAXL + 1);

  localparam logic [c_BW-1:0] c_BYTE_LAST = c_BW'(c_LINE_CYC - 1);
  localparam logic [c_BW-1:0] c_DE_END    = c_BW'(2*H_ACTIVE);
  localparam logic [c_LW-1:0] c_VS_LAST   = c_LW'(VS_LINES - 1);
  localparam logic [c_LW-1:0] c_VB_LAST   = c_LW'(V_BACK - 1);
  localparam logic [c_LW-1:0] c_ACT_LAST  = c_LW'(V_ACTIVE - 1);
  localparam logic [c_LW-1:0] c_VF_LAST   = c_LW'(V_FRONT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [c_BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [c_LW-1:0] line_cnt_q, line_cnt_d;
  logic            ready_q;
  logic            vs_q;
  logic            de_q;
  logic [7:0]      pdata_q;
  logic [7:0]      lo_q;
  logic            underrun_q;
  logic            frame_done_q;

  logic [c_LW-1:0] w_line_last;
  logic            w_in_de;
  logic            w_next_slot;
  logic [15:0]     w_pix;
  logic [15:0]     w_slot_pix;

`ifdef RGB565_RB_SWAP_EN
  assign w_pix = {pix.pix_data[4:0], pix.pix_data[10:5], pix.pix_data[15:11]};
`else
  assign w_pix = pix.pix_data;
`endif

  // A starved slot still occupies its two byte times, carrying black.
  assign w_slot_pix = pix.pix_valid ? w_pix : 16'h0000;

  always_comb begin
    w_line_last = '0;
    case (state_q)
      ST_VSYNC:  w_line_last = c_VS_LAST;
      ST_VBACK:  w_line_last = c_VB_LAST;
      ST_ACTIVE: w_line_last = c_ACT_LAST;
      ST_VFRONT: w_line_last = c_VF_LAST;
      default:   w_line_last = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    if (state_q == ST_IDLE) begin
      if (enable) state_d = ST_VSYNC;
    end else if (byte_cnt_q == c_BYTE_LAST) begin
      byte_cnt_d = '0;
      if (line_cnt_q == w_line_last) begin
        line_cnt_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          ST_VFRONT: state_d = enable ? ST_VSYNC : ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        line_cnt_d = line_cnt_q + c_LW'(1);
      end
    end else begin
      byte_cnt_d = byte_cnt_q + c_BW'(1);
    end
  end

  // Outputs trail the line/byte counters by one clock, so the counter
  // position one ahead tells us when to raise pix_ready.
  assign w_in_de     = (state_q == ST_ACTIVE) && (byte_cnt_q < c_DE_END);
  assign w_next_slot = (state_d == ST_ACTIVE) && (byte_cnt_d < c_DE_END) && !byte_cnt_d[0];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      line_cnt_q   <= '0;
      ready_q      <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      pdata_q      <= 8'h00;
      lo_q         <= 8'h00;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      line_cnt_q   <= line_cnt_d;
      ready_q      <= w_next_slot;
      vs_q         <= (state_q == ST_VSYNC);
      de_q         <= w_in_de;
      frame_done_q <= (state_q == ST_ACTIVE) && (line_cnt_q == c_ACT_LAST) &&
                      (byte_cnt_q == c_DE_END);
      if (ready_q) begin
        pdata_q <= w_slot_pix[15:8];
        lo_q    <= w_slot_pix[7:0];
        if (!pix.pix_valid) underrun_q <= 1'b1;
      end else if (w_in_de) begin
        pdata_q <= lo_q;
      end else begin
        pdata_q <= 8'h00;
      end
      if ((state_q == ST_VSYNC) && (line_cnt_q == '0) && (byte_cnt_q == '0))
        underrun_q <= 1'b0;
    end
  end

  assign pix.pix_ready = ready_q;
  assign vs_o          = vs_q;
  assign de_o          = de_q;
  assign pdata_o       = pdata_q;
  assign underrun_o    = underrun_q;
  assign frame_done_o  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb565_dvp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb565_dvp_tx
// Brief    : Self-checking bench for rgb565_dvp_tx against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb565_dvp_tx;
  localparam int H_ACTIVE = 4;
  localparam int H_BLANK  = 3;
  localparam int V_ACTIVE = 2;
  localparam int VS_LINES = 1;
  localparam int V_BACK   = 1;
  localparam int V_FRONT  = 1;
  localparam int L        = 2*H_ACTIVE + H_BLANK;
  localparam int FRAME    = (VS_LINES + V_BACK + V_ACTIVE + V_FRONT) * L;
  localparam int ACT0     = (VS_LINES + V_BACK) * L;
  localparam int FD_POS   = ACT0 + (V_ACTIVE - 1) * L + 2*H_ACTIVE;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       vs_o, de_o, underrun_o, frame_done_o;
  logic [7:0] pdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  rgb565_dvp_tx_if pif ();

  rgb565_dvp_tx #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VS_LINES(VS_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pix         (pif),
    .vs_o        (vs_o),
    .de_o        (de_o),
    .pdata_o     (pdata_o),
    .underrun_o  (underrun_o),
    .frame_done_o(frame_done_o)
  );

  always #5 pclk = ~pclk;

  // Reference model: one position counter across the whole frame.
  bit          m_run;
  int          m_sp;
  logic [7:0]  m_lo;
  bit          m_und;
  bit          m_take;
  logic        e_vs, e_de, e_fd, e_rdy, e_und;
  logic [7:0]  e_pd;
  logic [15:0] cur_pix;
  logic [15:0] pq[$];

  function automatic int col_of(int sp);
    if (sp >= ACT0 && sp < ACT0 + V_ACTIVE*L) return (sp - ACT0) % L;
    return -1;
  endfunction

  function automatic logic [15:0] xform(logic [15:0] p);
`ifdef RGB565_RB_SWAP_EN
    return {p[4:0], p[10:5], p[15:11]};
`else
    return p;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_sp = 0; m_lo = 8'h00; m_und = 0;
    e_vs = 0; e_de = 0; e_fd = 0; e_rdy = 0; e_und = 0; e_pd = 8'h00;
  endtask

  task automatic model_edge();
    int col;
    logic [15:0] px;
    if (!rst_n) begin
      model_reset();
      return;
    end
    col  = m_run ? col_of(m_sp) : -1;
    e_vs = m_run && (m_sp < VS_LINES*L);
    e_de = (col >= 0) && (col < 2*H_ACTIVE);
    e_fd = m_run && (m_sp == FD_POS);
    if (e_de && (col % 2 == 0)) begin
      if (pif.pix_valid) begin
        px = xform(pif.pix_data);
        m_take = 1;
      end else begin
        px = 16'h0000;
        m_und = 1;
      end
      e_pd = px[15:8];
      m_lo = px[7:0];
    end else if (e_de) begin
      e_pd = m_lo;
    end else begin
      e_pd = 8'h00;
    end
    if (m_run && m_sp == 0) m_und = 0;
    e_und = m_und;
    if (!m_run) begin
      if (enable) begin m_run = 1; m_sp = 0; end
    end else if (m_sp == FRAME - 1) begin
      if (enable) m_sp = 0; else m_run = 0;
    end else begin
      m_sp++;
    end
    col   = m_run ? col_of(m_sp) : -1;
    e_rdy = (col >= 0) && (col < 2*H_ACTIVE) && (col % 2 == 0);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    chk("vs_o",         16'(vs_o),          16'(e_vs));
    chk("de_o",         16'(de_o),          16'(e_de));
    chk("pdata_o",      16'(pdata_o),       16'(e_pd));
    chk("pix_ready",    16'(pif.pix_ready), 16'(e_rdy));
    chk("underrun_o",   16'(underrun_o),    16'(e_und));
    chk("frame_done_o", 16'(frame_done_o),  16'(e_fd));
  endtask

  task automatic next_pix();
    if (pq.size() > 0) cur_pix = pq.pop_front();
    else               cur_pix = 16'($urandom);
  endtask

  task automatic cycle();
    @(posedge pclk);
    model_edge();
    @(negedge pclk);
    chk_outputs();
    if (m_take) begin
      next_pix();
      m_take = 0;
    end
    pif.pix_data = cur_pix;
  endtask

  initial begin
    m_take        = 0;
    rst_n         = 1'b1;
    enable        = 1'b0;
    pif.pix_valid = 1'b0;
    cur_pix       = 16'h1234;
    pq            = '{16'hABCD, 16'h00FF, 16'hF800};
    pif.pix_data  = cur_pix;
    model_reset();

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_outputs();
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Continuous stream, known pixels first, two back-to-back frames.
    enable        = 1'b1;
    pif.pix_valid = 1'b1;
    repeat (2*FRAME) cycle();

    // Random starvation over two frames.
    repeat (2*FRAME) begin
      pif.pix_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drop enable during the first active line; the frame must finish.
    pif.pix_valid = 1'b1;
    for (int i = 0; i < FRAME + 2; i++) begin
      if (m_run && m_sp == ACT0 + 3) break;
      cycle();
    end
    enable = 1'b0;
    repeat (FRAME + 20) cycle();

    // Restart, then pulse reset mid-line.
    enable = 1'b1;
    for (int i = 0; i < 2*FRAME; i++) begin
      if (m_run && m_sp == ACT0 + L + 5) break;
      pif.pix_valid = ($urandom_range(0, 1) != 0);
      cycle();
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1 chk_outputs();
    repeat (2) cycle();
    rst_n         = 1'b1;
    pif.pix_valid = 1'b1;
    repeat (FRAME + 20) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rgb565_dvp_tx.md
RGB565_DVP_TX -- requirements
Module: rgb565_dvp_tx

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL expose parameter H_ACTIVE, default 1280, active pixels per line.
REQ-003 SHALL expose parameter H_BLANK, default 160, blank byte-clocks per line.
REQ-004 SHALL expose parameter V_ACTIVE, default 720, active lines per frame.
REQ-005 SHALL expose parameters VS_LINES/V_BACK/V_FRONT, defaults 4/20/5, vsync, back-porch and front-porch lengths in lines.
REQ-006 pclk  in  1  byte clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  run request; sampled only at frame boundaries.
REQ-009 pix_data  in  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
REQ-010 pix_valid  in  1  pix_data is valid.
REQ-011 pix_ready  out  1  block accepts pix_data this cycle.
REQ-012 vs_o  out  1  DVP vertical sync, active high.
REQ-013 de_o  out  1  DVP line-valid (HREF).
REQ-014 pdata_o  out  8  DVP byte data.
REQ-015 underrun_o  out  1  sticky pixel-starvation flag.
REQ-016 frame_done_o  out  1  one-cycle pulse after last active byte of a frame.

Function
REQ-017 SHALL implement states IDLE, VSYNC, VBACK, ACTIVE, VFRONT; line length LINE_CYC = 2*H_ACTIVE + H_BLANK clocks in every non-IDLE state.
REQ-018 IDLE -> VSYNC when enable=1; VSYNC -> VBACK after VS_LINES lines; VBACK -> ACTIVE after V_BACK lines; ACTIVE -> VFRONT after V_ACTIVE lines; VFRONT -> VSYNC if enable=1 else IDLE after V_FRONT lines.
REQ-019 enable deasserted mid-frame SHALL NOT truncate the frame; the frame completes through VFRONT.
REQ-020 vs_o SHALL be 1 for exactly VS_LINES*LINE_CYC consecutive clocks per frame, 0 otherwise.
REQ-021 In ACTIVE, each line SHALL drive de_o=1 for 2*H_ACTIVE clocks then de_o=0 for H_BLANK clocks; de_o=0 in all other states.
REQ-022 Each pixel SHALL be emitted as two bytes, pix[15:8] on the first de_o cycle of the pair, pix[7:0] on the second.
REQ-023 vs_o, de_o, pdata_o SHALL be registered and mutually aligned; pdata_o=0x00 whenever de_o=0.
REQ-024 pix_ready SHALL be 1 exactly in the cycle before each even (high) byte of an active line, 0 otherwise; a pixel accepted (pix_ready&pix_valid) at edge N SHALL show its high byte on pdata_o after edge N.
REQ-025 pix_ready&!pix_valid SHALL emit pixel 0x0000 for that slot and set underrun_o; no pixel is consumed.
REQ-026 underrun_o SHALL clear on the first clock of each VSYNC state and otherwise hold.
REQ-027 frame_done_o SHALL pulse 1 cycle, on the clock after the last de_o=1 byte of line V_ACTIVE.
REQ-028 Line and byte counters SHALL wrap to 0 at line/state end with no skipped or duplicated clock.

Reset
REQ-029 rst_n=0 SHALL force state IDLE, counters 0, vs_o=0, de_o=0, pdata_o=0x00, pix_ready=0, underrun_o=0, frame_done_o=0, immediately and independent of pclk.
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release the block restarts from IDLE with a full VSYNC.

Configuration
REQ-031 With macro RGB565_RB_SWAP_EN defined, each pixel SHALL be transformed to {pix[4:0],pix[10:5],pix[15:11]} before byte splitting; undefined, pixels SHALL be sent unmodified.

Verification (H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, VS_LINES=1, V_BACK=1, V_FRONT=1, LINE_CYC=11)
REQ-032 enable=1 from reset, pix_valid=1 -> vs_o high 11 clocks, 11 idle clocks, then de_o high 8 clocks, low 3, twice; frame repeats every 55 clocks.
REQ-033 pixels 0x1234,0xABCD,0x00FF,0xF800 -> pdata_o 12,34,AB,CD,00,FF,F8,00 with de_o=1, one pix_ready per 2 clocks.
REQ-034 pix_valid=0 on 2nd pixel slot -> bytes 00,00 in that slot, underrun_o=1 until next vs_o rise, following pixel not skipped.
REQ-035 enable dropped during line 1 of ACTIVE -> frame completes, frame_done_o pulses once, vs_o stays 0 afterwards.
REQ-036 rst_n pulsed low mid-line -> all outputs 0 asynchronously; after release with enable=1 a full VSYNC precedes data.
REQ-037 RGB565_RB_SWAP_EN defined, pixel 0xF800 -> pdata_o 00,1F.
